mem_data_unit: RTL
==================

MEM_DATA_UNIT -- requirements
Module: mem_data_unit

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-003 SHALL have port pc_m, input, 32, PC of the MEM-stage instruction (used for trace only).
REQ-004 SHALL have port instr_m, input, 32, MEM-stage instruction word (0 = bubble).
REQ-005 SHALL have port addr_m, input, 32, byte address computed in EX (ALU result).
REQ-006 SHALL have port wdata_m, input, 32, store data (rt value).
REQ-007 SHALL have port rdata_m, output, 32, extended load result for the MEM/WB register.
REQ-008 SHALL have port be_m, output, 4, active byte lanes of the current access.
REQ-009 SHALL have port align_err, output, 1, high when the current load/store is misaligned.
REQ-010 SHALL have parameter DEPTH_LOG2, default 12, word-index width (4096 words).

Function
REQ-011 SHALL decode opcode instr_m[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28; all others are non-memory ops.
REQ-012 SHALL index storage with addr_m[DEPTH_LOG2+1:2]; higher address bits are ignored (wrap-around).
REQ-013 SHALL drive be_m: word 4'b1111; half 4'b0011 << addr_m[1:0]; byte 4'b0001 << addr_m[1:0]; 0 for non-memory ops and misaligned ops.
REQ-014 SHALL assert align_err combinationally for word ops with addr_m[1:0]!=0 and half ops with addr_m[0]=1; 0 otherwise.
REQ-015 SHALL, at posedge clk for a decoded store with align_err=0 and reset=0, update only the lanes in be_m, taking each lane's byte from wdata_m low bytes shifted by 8*addr_m[1:0].
REQ-016 SHALL suppress the write entirely on a misaligned store.
REQ-017 SHALL read combinationally: rdata_m reflects array contents before the current edge (write-first not applied; no load follows its own store in one cycle).
REQ-018 SHALL produce rdata_m: lw full word; lh/lb sign-extended selected lane(s); lhu/lbu zero-extended; 0 for non-load ops and misaligned loads.
REQ-019 SHALL treat instr_m=0 (flushed bubble) as a non-memory op: no write, rdata_m=0, be_m=0.
REQ-020 SHALL give store latency 1 cycle: data written at edge N is visible on rdata_m in cycle N+1.

Reset
REQ-021 SHALL clear every storage word to 0 at a rising edge with reset=1.
REQ-022 SHALL give reset priority over a simultaneous store; that store is lost.
REQ-023 SHALL keep outputs combinational from inputs and state; after reset, any load returns 0.

Configuration
REQ-024 SHALL, with DM_TRACE_EN defined, print one line per committed store: "@<pc_m hex>: *<word-aligned addr hex> <= <merged word hex>", where the merged word is the post-write word value.
REQ-025 SHALL, without DM_TRACE_EN, contain no simulation print statements; function is identical.

Structure
REQ-026 SHALL take opcode constants and the access-size enum (BYTE/HALF/WORD) from the shared package cpu_defs_pkg.
REQ-027 SHALL place load extension in one sub-module, load_ext (inputs: word, addr[1:0], size, signed; output: 32-bit result).
REQ-028 SHALL be 120-400 RTL lines with no other sub-modules.

Verification
REQ-029 SHALL cover: reset, then lw addr 0x0000_0010 -> rdata_m=0x0000_0000, be_m=4'b1111.
REQ-030 SHALL cover: sw 0x1234_5678 to 0x20, then lb 0x23 -> 0x0000_0012; lb 0x20 -> 0x0000_0078; lh 0x22 -> 0x0000_1234.
REQ-031 SHALL cover: sw 0x0000_80F0 to 0x40, then lh 0x40 -> 0xFFFF_80F0; lhu 0x40 -> 0x0000_80F0; lbu 0x40 -> 0x0000_00F0.
REQ-032 SHALL cover: sw 0xAABB_CCDD to 0x30, sb wdata 0x11 to 0x31 -> word at 0x30 = 0xAABB_11DD; sh wdata 0x2233 to 0x32 -> 0x2233_11DD.
REQ-033 SHALL cover: sw to 0x42 -> align_err=1, be_m=0, word at 0x40 unchanged; store with reset=1 in the same cycle -> word reads 0.
REQ-034 SHALL cover: sw 0xCAFE_0001 to 0x4000 -> lw 0x0000 returns 0xCAFE_0001 (wrap), and with DM_TRACE_EN the printed line shows addr 0x00004000.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: MEM-stage opcodes and the access-size encoding.
package cpu_defs_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;

endpackage

// File: rtl/mem_data_unit_load_ext.sv
// Load extension: picks the addressed byte/half/word lane and sign- or zero-extends it.
module load_ext
    import cpu_defs_pkg::*;
(
    input  logic [31:0]  word,
    input  logic [1:0]   addr,
    input  access_size_t size,
    input  logic         is_signed,
    output logic [31:0]  result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = word >> {addr, 3'b000};
        result  = '0;
        case (size)
            WORD:    result = word;
            HALF:    result = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            BYTE:    result = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_data_unit.sv
// MEM-stage data memory: decode, byte-lane enables, alignment check, storage and load extension.
// Optional store trace printing is enabled with the DM_TRACE_EN macro.
module mem_data_unit
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [31:0] instr_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic [31:0] rdata_m,
    output logic [3:0]  be_m,
    output logic        align_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  is_load;
    logic                  is_store;
    logic                  is_signed;
    access_size_t          size;
    logic [3:0]            be;
    logic                  mis;
    logic                  wr_en;
    logic [31:0]           rd_word;
    logic [31:0]           wshift;
    logic [31:0]           merged_d;
    logic [31:0]           ext_word;
    logic                  unused_bits;

    assign idx         = addr_m[DEPTH_LOG2+1:2];
    assign rd_word     = mem_q[idx];
    assign unused_bits = ^{pc_m, instr_m[25:0], addr_m[31:DEPTH_LOG2+2]};

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = WORD;
        case (instr_m[31:26])
            OP_LW:  begin is_load  = 1'b1; size = WORD; end
            OP_LH:  begin is_load  = 1'b1; size = HALF; is_signed = 1'b1; end
            OP_LHU: begin is_load  = 1'b1; size = HALF; end
            OP_LB:  begin is_load  = 1'b1; size = BYTE; is_signed = 1'b1; end
            OP_LBU: begin is_load  = 1'b1; size = BYTE; end
            OP_SW:  begin is_store = 1'b1; size = WORD; end
            OP_SH:  begin is_store = 1'b1; size = HALF; end
            OP_SB:  begin is_store = 1'b1; size = BYTE; end
            default: ;
        endcase
    end

    always_comb begin
        mis = 1'b0;
        be  = 4'b0000;
        if (is_load || is_store) begin
            case (size)
                WORD:    mis = (addr_m[1:0] != 2'b00);
                HALF:    mis = addr_m[0];
                default: mis = 1'b0;
            endcase
            if (!mis) begin
                case (size)
                    WORD:    be = 4'b1111;
                    HALF:    be = 4'b0011 << addr_m[1:0];
                    default: be = 4'b0001 << addr_m[1:0];
                endcase
            end
        end
    end

    assign align_err = mis;
    assign be_m      = be;
    assign wr_en     = is_store && !mis;

    // Lane merge against the current word so only enabled bytes change.
    always_comb begin
        wshift   = wdata_m << {addr_m[1:0], 3'b000};
        merged_d = rd_word;
        for (int l = 0; l < 4; l++) begin
            if (be[l]) merged_d[8*l +: 8] = wshift[8*l +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[idx] <= merged_d;
`ifdef DM_TRACE_EN
            $display("@%08h: *%08h <= %08h", pc_m, {addr_m[31:2], 2'b00}, merged_d);
`endif
        end
    end

    load_ext u_load_ext (
        .word      (rd_word),
        .addr      (addr_m[1:0]),
        .size      (size),
        .is_signed (is_signed),
        .result    (ext_word)
    );

    assign rdata_m = (is_load && !mis) ? ext_word : 32'h0;

endmodule
